// File: rtl/sram_frame_ctrl.sv
// rtl/sram_frame_ctrl.sv - camera pixel FIFO, SRAM write sequencing and display read interleave
// Drives the SRAM interface control-state/address/data inputs; returns read data with fixed latency.
module sram_frame_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 76800,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFrameStart,
    input  logic              iPixValid,
    input  logic [DATA_W-1:0] iPixData,
    input  logic              iRdReq,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic              oRdAck,
    output logic              oRdValid,
    output logic [DATA_W-1:0] oRdData,
    output logic              oControlState,
    output logic [ADDR_W-1:0] oMemoryWriteAddress,
    output logic [ADDR_W-1:0] oMemoryReadAddress,
    output logic [DATA_W-1:0] oMemoryData,
    input  logic [DATA_W-1:0] iMemoryData,
    output logic              oFrameDone,
    output logic              oOverflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     HALF = CW'(FIFO_DEPTH / 2);
    localparam logic [CW-1:0]     FULL = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WR, WRH, RD0, RD1} state_t;

    state_t            state;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] wcnt;
    logic              cap_pend;

    logic              arb, go_wr, go_rd, push, wrap, inc;
    logic [CW-1:0]     eff_count;
    logic [ADDR_W-1:0] wcnt_next;

    // A frame start flushes the FIFO, so arbitration sees it as empty that cycle.
    always_comb begin
        arb       = (state == IDLE) || (state == WRH) || (state == RD1);
        eff_count = iFrameStart ? '0 : count;
        go_wr     = arb && ((eff_count >= HALF) || (!iRdReq && (eff_count != '0)));
        go_rd     = arb && !go_wr && iRdReq;
        push      = iPixValid && (iFrameStart || (count != FULL) || go_wr);
        inc       = (state == WRH);
        wrap      = (wcnt == LAST);
        wcnt_next = wcnt;
        if (iFrameStart)
            wcnt_next = '0;
        else if (inc)
            wcnt_next = wrap ? '0 : wcnt + ADDR_W'(1);
    end

    always_ff @(posedge iCLK) begin
        if (push)
            fifo_mem[iFrameStart ? '0 : wr_ptr] <= iPixData;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            wcnt                <= '0;
            cap_pend            <= 1'b0;
            oRdAck              <= 1'b0;
            oRdValid            <= 1'b0;
            oRdData             <= '0;
            oControlState       <= 1'b0;
            oMemoryWriteAddress <= '0;
            oMemoryReadAddress  <= '0;
            oMemoryData         <= '0;
            oFrameDone          <= 1'b0;
            oOverflow           <= 1'b0;
        end else begin
            if (iFrameStart) begin
                rd_ptr <= '0;
                wr_ptr <= push ? PW'(1) : '0;
                count  <= push ? CW'(1) : '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (go_wr)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(go_wr);
            end
            oOverflow  <= oOverflow | (iPixValid && !push);
            wcnt       <= wcnt_next;
            oFrameDone <= inc && wrap;

            oControlState <= go_wr;
            oRdAck        <= go_rd;
            if (go_wr) begin
                oMemoryData         <= fifo_mem[rd_ptr];
                oMemoryWriteAddress <= wcnt_next;
            end
            if (go_rd)
                oMemoryReadAddress <= iRdAddr;

            case (state)
                WR:      state <= WRH;
                RD0:     state <= RD1;
                default: state <= go_wr ? WR : (go_rd ? RD0 : IDLE);
            endcase

            // SRAM interface registers the word at the end of RD1; take it one edge later.
            cap_pend <= (state == RD1);
            oRdValid <= cap_pend;
            if (cap_pend)
                oRdData <= iMemoryData;
        end
    end
endmodule

// File: tb/tb_sram_frame_ctrl.sv
// tb/tb_sram_frame_ctrl.sv - randomized bench for sram_frame_ctrl against a schedule-based reference model
module tb_sram_frame_ctrl;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int FW   = 6;
    localparam int FD   = 8;
    localparam int NCYC = 1300;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iFrameStart = 1'b0;
    logic          iPixValid = 1'b0;
    logic [DW-1:0] iPixData = '0;
    logic          iRdReq = 1'b0;
    logic [AW-1:0] iRdAddr = '0;
    logic          oRdAck, oRdValid, oControlState, oFrameDone, oOverflow;
    logic [DW-1:0] oRdData, oMemoryData;
    logic [AW-1:0] oMemoryWriteAddress, oMemoryReadAddress;
    logic [DW-1:0] iMemoryData = '0;

    sram_frame_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFrameStart(iFrameStart), .iPixValid(iPixValid),
        .iPixData(iPixData), .iRdReq(iRdReq), .iRdAddr(iRdAddr), .oRdAck(oRdAck),
        .oRdValid(oRdValid), .oRdData(oRdData), .oControlState(oControlState),
        .oMemoryWriteAddress(oMemoryWriteAddress), .oMemoryReadAddress(oMemoryReadAddress),
        .oMemoryData(oMemoryData), .iMemoryData(iMemoryData), .oFrameDone(oFrameDone),
        .oOverflow(oOverflow)
    );

    always #10 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Expected outputs per cycle, filled in ahead of time by the model.
    bit            e_cs[NCYC+8], e_ack[NCYC+8], e_val[NCYC+8], e_fd[NCYC+8], e_ovf[NCYC+8];
    bit            e_zero[NCYC+8], e_wchk[NCYC+8], e_rchk[NCYC+8];
    logic [AW-1:0] e_wa[NCYC+8], e_ra[NCYC+8];
    logic [DW-1:0] e_wd[NCYC+8], e_rdata[NCYC+8];

    logic [DW-1:0] model_mem[1<<AW];
    logic [DW-1:0] sram[1<<AW];
    logic [DW-1:0] q[$];
    int            wcnt, next_dec, inc_at;
    bit            ovf;

    // One cycle of the reference: a new 2-cycle operation may be chosen whenever the previous one has ended.
    task automatic model_step(input int n, input bit rst, input bit fs, input bit pv,
                              input logic [DW-1:0] pd, input bit rq, input logic [AW-1:0] ra);
        int sz;
        bit was_last;
        if (rst) begin
            q.delete();
            wcnt = 0; ovf = 0; inc_at = -1; next_dec = n + 1;
            for (int k = n + 1; k <= n + 5; k++) begin
                e_cs[k] = 0; e_ack[k] = 0; e_val[k] = 0; e_fd[k] = 0; e_ovf[k] = 0;
                e_zero[k] = 0; e_wchk[k] = 0; e_rchk[k] = 0;
            end
            e_zero[n+1] = 1;
            return;
        end
        was_last = (wcnt == FW - 1);
        e_fd[n+1] = (n == inc_at) && was_last;
        if (fs)
            wcnt = 0;
        else if (n == inc_at)
            wcnt = was_last ? 0 : wcnt + 1;
        if (n >= next_dec) begin
            sz = fs ? 0 : q.size();
            if (sz >= FD / 2 || (!rq && sz > 0)) begin
                e_cs[n+1] = 1;
                e_wd[n+1] = q.pop_front();
                e_wchk[n+1] = 1; e_wchk[n+2] = 1;
                e_wa[n+1] = AW'(wcnt); e_wa[n+2] = AW'(wcnt);
                model_mem[wcnt] = e_wd[n+1];
                inc_at = n + 2;
                next_dec = n + 2;
            end else if (rq) begin
                e_ack[n+1] = 1;
                e_rchk[n+1] = 1; e_rchk[n+2] = 1;
                e_ra[n+1] = ra; e_ra[n+2] = ra;
                e_val[n+4] = 1;
                e_rdata[n+4] = model_mem[ra];
                next_dec = n + 2;
            end else begin
                next_dec = n + 1;
            end
        end
        if (fs)
            q.delete();
        if (pv) begin
            if (q.size() < FD) q.push_back(pd);
            else ovf = 1;
        end
        e_ovf[n+1] = ovf;
    endtask

    task automatic check_cycle(input int n);
        check("ctrl_state", oControlState, e_cs[n]);
        check("rd_ack", oRdAck, e_ack[n]);
        check("rd_valid", oRdValid, e_val[n]);
        check("frame_done", oFrameDone, e_fd[n]);
        check("overflow", oOverflow, e_ovf[n]);
        if (e_val[n])  check("rd_data", oRdData, e_rdata[n]);
        if (e_wchk[n]) check("wr_addr", oMemoryWriteAddress, e_wa[n]);
        if (e_cs[n])   check("wr_data", oMemoryData, e_wd[n]);
        if (e_rchk[n]) check("rd_addr", oMemoryReadAddress, e_ra[n]);
        if (e_zero[n]) begin
            check("rst_wr_addr", oMemoryWriteAddress, 0);
            check("rst_wr_data", oMemoryData, 0);
            check("rst_rd_addr", oMemoryReadAddress, 0);
            check("rst_rd_data", oRdData, 0);
        end
    endtask

    initial begin
        bit            rq_on, rst_done, fs, pv;
        int            rst_left, p_rd, p_pix, p_fs;
        logic [AW-1:0] ra_prev;
        logic [DW-1:0] pd;
        rq_on = 0; rst_done = 0; rst_left = 0; ra_prev = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = DW'($urandom);
            model_mem[i] = sram[i];
        end
        wcnt = 0; ovf = 0; inc_at = -1; next_dec = 0;
        e_zero[0] = 1;
        repeat (2) @(posedge iCLK);

        for (int n = 0; n < NCYC; n++) begin
            @(negedge iCLK);
            cyc = n;
            check_cycle(n);
            // Behavioural SRAM: registered read of last cycle's address, write on WR cycles.
            iMemoryData = sram[ra_prev];
            ra_prev = oMemoryReadAddress;
            if (oControlState) sram[oMemoryWriteAddress] = oMemoryData;

            fs = 0; pv = 0; pd = DW'($urandom); p_rd = 0; p_pix = 0; p_fs = 0;
            if (n < 40) begin
                fs = (n == 2);
                pv = (n == 4 || n == 6 || n == 8 || n == 10);
                pd = DW'(16'h0011 * ((n - 2) / 2));
            end else if (n < 100) begin
                p_rd = 50;
            end else if (n < 400) begin
                p_rd = 40; p_pix = 45; p_fs = 2;
            end else if (n < 420) begin
                p_rd = 100; pv = 1;
            end else if (!rst_done) begin
                if (n == 420) check("ovf_sticky", oOverflow, 1);
                if (e_cs[n] || n == 460) begin
                    check("rst_mid_wr", oControlState, 1);
                    rst_done = 1; rst_left = 2;
                end
            end else if (n < NCYC - 20) begin
                p_rd = 40; p_pix = 40; p_fs = 3;
            end
            if (p_pix > 0) pv = ($urandom_range(99) < p_pix);
            if (p_fs > 0)  fs = ($urandom_range(99) < p_fs);

            if (e_ack[n]) rq_on = 0;
            if (!rq_on && $urandom_range(99) < p_rd) begin
                rq_on = 1;
                iRdAddr = AW'($urandom);
            end

            iRST = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            iFrameStart = fs;
            iPixValid = pv;
            iPixData = pd;
            iRdReq = rq_on;
            model_step(n, iRST, fs, pv, pd, rq_on, iRdAddr);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
